// File: rtl/sample_tx.sv
// Transmit side of the sample path: a small FIFO fed from the bus side, drained one
// sample at a time to the filter under a data_ready / modwait handshake.
module sample_tx #(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int BLOCK_LEN = 1000,
  parameter int CNT_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  input  logic              clear,
  input  logic              modwait,
  output logic [DATA_W-1:0] sample_data,
  output logic              data_ready,
  output logic [CNT_W-1:0]  samples_issued,
  output logic              block_done,
  output logic              overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [OW-1:0]     count;
  logic [OW-1:0]     count_nxt;
  logic              push;
  logic              pop;

  // full/empty are the registered view of occupancy, so a push while full is
  // refused even when a pop frees a slot on the same edge.
  assign push = wr_en && !full && !clear;
  assign pop  = (state == IDLE) && !empty && !modwait && !clear;

  // NOTE: every path assigns count_nxt first, so no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + OW'(1);
      2'b01:   count_nxt = count - OW'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      overrun <= 1'b0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == OW'(DEPTH));
      empty <= (count_nxt == '0);
      if (wr_en && full) overrun <= 1'b1;
    end
  end

  // NOTE: sample storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      sample_data    <= '0;
      data_ready     <= 1'b0;
      block_done     <= 1'b0;
      samples_issued <= '0;
    end else if (clear) begin
      state          <= IDLE;
      data_ready     <= 1'b0;
      block_done     <= 1'b0;
      samples_issued <= '0;
    end else begin
      data_ready <= 1'b0;
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state       <= ISSUE;
            sample_data <= mem[rd_ptr];
            data_ready  <= 1'b1;
            // The wrap edge is the same edge that raises data_ready, so both pulses align.
            if (samples_issued == CNT_W'(BLOCK_LEN - 1)) begin
              samples_issued <= '0;
              block_done     <= 1'b1;
            end else begin
              samples_issued <= samples_issued + CNT_W'(1);
            end
          end
        end
        ISSUE:     state <= WAIT_BUSY;
        WAIT_BUSY: if (modwait) state <= WAIT_DONE;
        WAIT_DONE: if (!modwait) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule
